// File: rtl/w_clk_module.sv
// rtl/w_clk_module.sv - write-clock side of an async FIFO: Gray write pointer, r_ptr sync, full/almost-full/overflow flags.
// Optional occupancy output w_level is enabled by defining W_LEVEL_EN.
module w_clk_module #(
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    w_clk,
    input  logic                    wrst_n,
    input  logic                    w_en,
    input  logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic                    w_inc,
    output logic                    w_full,
    output logic                    w_almost_full,
    output logic                    w_overflow,
    output logic [ADDRESS_SIZE:0]   w_level
);

    localparam int PW  = ADDRESS_SIZE + 1;
    localparam int MSB = ADDRESS_SIZE;
    localparam logic [PW-1:0] DEPTH_M1 = PW'((2 ** ADDRESS_SIZE) - 1);

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_bnext;
    logic [PW-1:0] w_gnext;
    logic [PW-1:0] wq1_rptr;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] rq2_bin;
    logic          full_next;
    logic          almost_full_next;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[MSB] = g[MSB];
        for (int i = MSB - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Gated by reset so a write in flight while reset is asserted never reaches memory.
    assign w_inc   = w_en & ~w_full & wrst_n;
    assign w_addr  = w_bin[ADDRESS_SIZE-1:0];
    assign w_bnext = w_bin + PW'(w_inc);
    assign w_gnext = w_bnext ^ (w_bnext >> 1);
    assign rq2_bin = gray2bin(wq2_rptr);

    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
    assign full_next = (w_gnext == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]});

`ifdef W_LEVEL_EN
    logic [PW-1:0] occ_next;

    assign occ_next         = w_bnext - rq2_bin;
    assign almost_full_next = (occ_next >= DEPTH_M1);

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            w_level <= '0;
        end else begin
            w_level <= occ_next;
        end
    end
`else
    // Occupancy never exceeds DEPTH, so ">= DEPTH-1" is "exactly DEPTH-1, or full".
    assign almost_full_next = full_next | (w_bnext == (rq2_bin + DEPTH_M1));
    assign w_level          = '0;
`endif

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= r_ptr;
            wq2_rptr <= wq1_rptr;
        end
    end

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            w_bin         <= '0;
            w_ptr         <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_overflow    <= 1'b0;
        end else begin
            w_bin         <= w_bnext;
            w_ptr         <= w_gnext;
            w_full        <= full_next;
            w_almost_full <= almost_full_next;
            if (w_en && w_full) begin
                w_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_w_clk_module.sv
// tb/tb_w_clk_module.sv - vector table, directed corner sequences and randomized model check for w_clk_module.
module tb_w_clk_module;

    localparam int AS = 2;
    localparam int PW = AS + 1;

    logic          w_clk = 1'b0;
    logic          wrst_n;
    logic          w_en;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr;
    logic [AS-1:0] w_addr;
    logic          w_inc;
    logic          w_full;
    logic          w_almost_full;
    logic          w_overflow;
    logic [PW-1:0] w_level;

    int total = 0;
    int bad   = 0;

    w_clk_module #(.ADDRESS_SIZE(AS)) dut (
        .w_clk(w_clk),
        .wrst_n(wrst_n),
        .w_en(w_en),
        .r_ptr(r_ptr),
        .w_ptr(w_ptr),
        .w_addr(w_addr),
        .w_inc(w_inc),
        .w_full(w_full),
        .w_almost_full(w_almost_full),
        .w_overflow(w_overflow),
        .w_level(w_level)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic       en;
        logic [2:0] rg;
        logic       inc;
        logic [1:0] addr;
        logic [2:0] ptr;
        logic       full;
        logic       af;
        logic       ovf;
    } vec_t;

    vec_t tbl[9];

    logic pre_inc;
    logic [AS-1:0] pre_addr;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] to_gray(input int b);
        logic [2:0] v;
        v = 3'(b % 8);
        return v ^ (v >> 1);
    endfunction

    // Drive inputs just after a falling edge, sample the combinational strobe, then step past the rising edge.
    task automatic cycle(input logic en, input logic [2:0] rg);
        @(negedge w_clk);
        w_en  = en;
        r_ptr = rg;
        #1;
        pre_inc  = w_inc;
        pre_addr = w_addr;
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        wrst_n = 1'b0;
        w_en   = 1'b0;
        r_ptr  = '0;
        @(negedge w_clk);
        wrst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ptr"}, int'(w_ptr), 0);
        chk({tag, "_addr"}, int'(w_addr), 0);
        chk({tag, "_inc"}, int'(w_inc), 0);
        chk({tag, "_full"}, int'(w_full), 0);
        chk({tag, "_af"}, int'(w_almost_full), 0);
        chk({tag, "_ovf"}, int'(w_overflow), 0);
        chk({tag, "_level"}, int'(w_level), 0);
    endtask

    // Reference model: plain write/read counters plus a two-deep history of the read count.
    int  m_wc, m_q1, m_q2, w_total, r_total, diff, wc_next;
    logic m_full, m_af, m_ovf, m_inc, en_r;
    logic [2:0] exp_gray [9];

    initial begin
        tbl[0] = '{1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 3'b000, 1'b1, 2'd1, 3'b011, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 3'b000, 1'b1, 2'd2, 3'b010, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 3'b000, 1'b1, 2'd3, 3'b110, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 3'b001, 1'b1, 2'd0, 3'b111, 1'b1, 1'b1, 1'b1};
        exp_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};

        wrst_n = 1'b0;
        w_en   = 1'b0;
        r_ptr  = '0;
        #12;
        chk_all_zero("reset");
        @(negedge w_clk);
        wrst_n = 1'b1;

        // Fill, overflow, then release one slot through the synchronizer.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].en, tbl[i].rg);
            chk($sformatf("vec%0d_inc", i), int'(pre_inc), int'(tbl[i].inc));
            chk($sformatf("vec%0d_addr", i), int'(pre_addr), int'(tbl[i].addr));
            chk($sformatf("vec%0d_ptr", i), int'(w_ptr), int'(tbl[i].ptr));
            chk($sformatf("vec%0d_full", i), int'(w_full), int'(tbl[i].full));
            chk($sformatf("vec%0d_af", i), int'(w_almost_full), int'(tbl[i].af));
            chk($sformatf("vec%0d_ovf", i), int'(w_overflow), int'(tbl[i].ovf));
        end

        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 3'b001);
            chk($sformatf("ovf_sticky%0d", i), int'(w_overflow), 1);
        end

        // Asynchronous reset pulse between edges during a write burst.
        @(negedge w_clk);
        w_en   = 1'b1;
        r_ptr  = '0;
        wrst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        #1;
        wrst_n = 1'b1;
        #1;
        chk("midrst_next_addr", int'(w_addr), 0);
        chk("midrst_next_inc", int'(w_inc), 1);
        @(posedge w_clk);
        #1;
        chk("midrst_ptr", int'(w_ptr), 1);

        // Nine writes with the reader keeping pace; pointer walks the Gray sequence through wrap.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, to_gray(i));
            chk($sformatf("wrap%0d_addr", i), int'(pre_addr), i % 4);
            chk($sformatf("wrap%0d_inc", i), int'(pre_inc), 1);
            chk($sformatf("wrap%0d_ptr", i), int'(w_ptr), int'(exp_gray[i]));
            chk($sformatf("wrap%0d_full", i), int'(w_full), 0);
        end

        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b000);
`ifdef W_LEVEL_EN
        chk("level3", int'(w_level), 3);
`else
        chk("level3", int'(w_level), 0);
`endif
        chk("level3_af", int'(w_almost_full), 1);
        chk("level3_full", int'(w_full), 0);

        // Randomized run against the counter model.
        do_reset();
        m_wc = 0; m_q1 = 0; m_q2 = 0; w_total = 0; r_total = 0;
        m_full = 1'b0; m_ovf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            en_r = ($urandom_range(0, 3) != 0);
            if (r_total < w_total && $urandom_range(0, 2) == 0) r_total++;
            m_inc   = en_r && !m_full;
            wc_next = (m_wc + int'(m_inc)) % 8;
            diff    = (wc_next - m_q2 + 8) % 8;
            cycle(en_r, to_gray(r_total));
            chk("rnd_inc", int'(pre_inc), int'(m_inc));
            chk("rnd_addr", int'(pre_addr), m_wc % 4);
            if (en_r && m_full) m_ovf = 1'b1;
            m_full = (diff == 4);
            m_af   = (diff >= 3);
            m_q2   = m_q1;
            m_q1   = r_total % 8;
            m_wc   = wc_next;
            w_total += int'(m_inc);
            chk("rnd_ptr", int'(w_ptr), int'(to_gray(m_wc)));
            chk("rnd_full", int'(w_full), int'(m_full));
            chk("rnd_af", int'(w_almost_full), int'(m_af));
            chk("rnd_ovf", int'(w_overflow), int'(m_ovf));
`ifdef W_LEVEL_EN
            chk("rnd_level", int'(w_level), diff);
`else
            chk("rnd_level", int'(w_level), 0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
